// File: rtl/cntr_mod_n.sv
// cntr_mod_n: modulo-N up/down counter with load, one-shot, compare match,
// sticky overflow and cascade tc. CNTR_PRESCALE_EN adds a ce prescaler.
module cntr_mod_n #(
  parameter int WIDTH     = 8,
  parameter int MODULUS   = 256,
  parameter int RESET_VAL = 0,
  parameter int PRESCALE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             cmp_match,
  output logic             ovf,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VAL);

  if (MODULUS < 2 || RESET_VAL >= MODULUS ||
      PRESCALE < 1 || PRESCALE > 256) begin : g_bad_param
    $error("cntr_mod_n: illegal parameter set");
  end

  logic             run;
  logic             step;
  logic             at_term;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] ld_sat;
  logic [WIDTH-1:0] out_nxt;

  // a load cycle never counts, so ce is qualified by ~load
  assign run     = ce & running & ~load;
  assign term    = dir ? MAX : '0;
  assign at_term = (out == term);
  assign tc      = step & at_term;

  // full binary range needs no clamp on the load value
  if (MODULUS >= (1 << WIDTH)) begin : g_full
    assign ld_sat = load_val;
  end else begin : g_part
    assign ld_sat = (load_val > MAX) ? MAX : load_val;
  end

`ifdef CNTR_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps;
  logic          ps_term;

  assign ps_term = (ps == PS_LAST);
  assign step    = run & ps_term;

  // prescaler: count qualified ce cycles 0..PRESCALE-1
  always_ff @(posedge clk) begin
    if (rst || load) begin
      ps <= '0;
    end else if (run) begin
      ps <= ps_term ? '0 : ps + PW'(1);
    end
  end
`else
  assign step = run;
`endif

  // next count value: load beats step; terminal wraps or holds
  always_comb begin
    out_nxt = out;
    if (load) begin
      out_nxt = ld_sat;
    end else if (step) begin
      if (at_term) begin
        if (!oneshot) begin
          out_nxt = dir ? '0 : MAX;
        end
      end else begin
        out_nxt = dir ? out + WIDTH'(1) : out - WIDTH'(1);
      end
    end
  end

  // state update: count, compare, sticky overflow, armed flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= RSTV;
      cmp_match <= 1'b0;
      ovf       <= 1'b0;
      running   <= 1'b1;
    end else begin
      out       <= out_nxt;
      cmp_match <= (out_nxt == cmp_val);
      if (tc) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
      if (load) begin
        running <= 1'b1;
      end else if (tc && oneshot) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cntr_mod_n.sv
// tb_cntr_mod_n: directed checks of cntr_mod_n (mod-10, 4 bit),
// a two-digit cascade and, with CNTR_PRESCALE_EN, a /4 prescaler.
module tb_cntr_mod_n;

`ifdef CNTR_PRESCALE_EN
  localparam int PS = 1;
`else
  localparam int PS = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       oneshot = 1'b0;
  logic [3:0] cmp_val = 4'd9;
  logic       clr_ovf = 1'b0;
  logic [3:0] out;
  logic       tc;
  logic       cmp_match;
  logic       ovf;
  logic       running;

  logic       cce = 1'b0;
  logic [3:0] lo_out, hi_out;
  logic       lo_tc, hi_tc;
  logic       lo_cm, hi_cm, lo_ovf, hi_ovf, lo_run, hi_run;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .ce(ce), .dir(dir), .load(load),
    .load_val(load_val), .oneshot(oneshot), .cmp_val(cmp_val),
    .clr_ovf(clr_ovf), .out(out), .tc(tc), .cmp_match(cmp_match),
    .ovf(ovf), .running(running)
  );

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .PRESCALE(PS)) u_lo (
    .clk(clk), .rst(rst), .ce(cce), .dir(1'b1), .load(1'b0),
    .load_val(4'd0), .oneshot(1'b0), .cmp_val(4'd0), .clr_ovf(1'b0),
    .out(lo_out), .tc(lo_tc), .cmp_match(lo_cm), .ovf(lo_ovf),
    .running(lo_run)
  );

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .PRESCALE(PS)) u_hi (
    .clk(clk), .rst(rst), .ce(lo_tc), .dir(1'b1), .load(1'b0),
    .load_val(4'd0), .oneshot(1'b0), .cmp_val(4'd0), .clr_ovf(1'b0),
    .out(hi_out), .tc(hi_tc), .cmp_match(hi_cm), .ovf(hi_ovf),
    .running(hi_run)
  );

`ifdef CNTR_PRESCALE_EN
  logic       pce = 1'b0;
  logic [3:0] p_out;
  logic       p_tc, p_cm, p_ovf, p_run;

  cntr_mod_n #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .PRESCALE(4)) u_ps (
    .clk(clk), .rst(rst), .ce(pce), .dir(1'b1), .load(1'b0),
    .load_val(4'd0), .oneshot(1'b0), .cmp_val(4'd0), .clr_ovf(1'b0),
    .out(p_out), .tc(p_tc), .cmp_match(p_cm), .ovf(p_ovf),
    .running(p_run)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e2[6]  = '{3, 2, 1, 0, 9, 8};
    int e3[5]  = '{7, 8, 9, 9, 9};
    int r3[5]  = '{1, 1, 1, 0, 0};
    int t3[5]  = '{0, 0, 1, 0, 0};

    // reset state
    tick();
    tick();
    chk("rst_out", 32'(out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_run", 32'(running), 1);
    chk("rst_cm", 32'(cmp_match), 0);

    // 1: count up through the wrap
    rst = 1'b0;
    ce  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_out", 32'(out), 32'(i % 10));
      chk("up_tc", 32'(tc), 32'((i % 10) == 9));
      chk("up_ovf", 32'(ovf), 32'(i >= 10));
      chk("up_cm", 32'(cmp_match), 32'((i % 10) == 9));
      tick();
    end

    // 2: load 3, count down through the wrap
    ce       = 1'b0;
    dir      = 1'b0;
    load     = 1'b1;
    load_val = 4'd3;
    tick();
    load = 1'b0;
    ce   = 1'b1;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("dn_out", 32'(out), 32'(e2[j]));
      chk("dn_tc", 32'(tc), 32'(e2[j] == 0));
      chk("dn_cm", 32'(cmp_match), 32'(e2[j] == 9));
      tick();
    end
    ce = 1'b0;

    // 3: one-shot stops at terminal, load re-arms
    oneshot  = 1'b1;
    dir      = 1'b1;
    load     = 1'b1;
    load_val = 4'd7;
    tick();
    load = 1'b0;
    ce   = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("os_out", 32'(out), 32'(e3[j]));
      chk("os_run", 32'(running), 32'(r3[j]));
      chk("os_tc", 32'(tc), 32'(t3[j]));
      tick();
    end
    ce       = 1'b0;
    load     = 1'b1;
    load_val = 4'd2;
    tick();
    load = 1'b0;
    chk("rearm_run", 32'(running), 1);
    chk("rearm_out", 32'(out), 2);
    oneshot = 1'b0;

    // 4: simultaneous events
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);
    load     = 1'b1;
    load_val = 4'd9;
    tick();
    load_val = 4'd4;
    ce       = 1'b1;
    #1;
    chk("ld_ce_tc", 32'(tc), 0);
    tick();
    load = 1'b0;
    ce   = 1'b0;
    chk("ld_ce_out", 32'(out), 4);
    chk("ld_ce_ovf", 32'(ovf), 0);
    load     = 1'b1;
    load_val = 4'd9;
    tick();
    load    = 1'b0;
    ce      = 1'b1;
    clr_ovf = 1'b1;
    #1;
    chk("wrap_tc", 32'(tc), 1);
    tick();
    ce      = 1'b0;
    clr_ovf = 1'b0;
    chk("wrap_out", 32'(out), 0);
    chk("set_wins", 32'(ovf), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_only", 32'(ovf), 0);
    load     = 1'b1;
    load_val = 4'd12;
    tick();
    load = 1'b0;
    chk("ld_sat", 32'(out), 9);

    // 5: two-digit cascade
    cce = 1'b1;
    for (int k = 0; k < 101; k++) begin
      #1;
      chk("casc", 32'(int'(hi_out) * 10 + int'(lo_out)), 32'(k % 100));
      tick();
    end
    cce = 1'b0;
    chk("casc_hi_ovf", 32'(hi_ovf), 1);

`ifdef CNTR_PRESCALE_EN
    // 6a: /4 prescaler
    pce = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      chk("ps_out", 32'(p_out), 32'(k / 4));
      tick();
    end
    pce = 1'b1;
`endif

    // 6: reset mid-operation beats load, ce and clr_ovf
    load     = 1'b1;
    load_val = 4'd9;
    tick();
    load = 1'b0;
    ce   = 1'b1;
    tick();
    tick();
    chk("pre_rst_out", 32'(out), 1);
    chk("pre_rst_ovf", 32'(ovf), 1);
    cmp_val  = 4'd0;
    rst      = 1'b1;
    load     = 1'b1;
    load_val = 4'd5;
    clr_ovf  = 1'b0;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    ce   = 1'b0;
    chk("mid_rst_out", 32'(out), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_run", 32'(running), 1);
    chk("mid_rst_cm", 32'(cmp_match), 0);
    tick();
    chk("post_rst_cm", 32'(cmp_match), 1);

`ifdef CNTR_PRESCALE_EN
    // 6b: reset cleared the prescaler; pce stayed high since the reset
    chk("ps_rst_out", 32'(p_out), 0);
    tick();
    tick();
    chk("ps_rst_mid", 32'(p_out), 0);
    tick();
    chk("ps_rst_step", 32'(p_out), 1);
    pce = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
